// File: rtl/axi_dac_reader_pkg.sv
// Shared types, AXI constants and sample-lane helpers for the AXI DAC reader.
package axi_dac_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int unsigned SMP_W  = 14;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned BEAT_W = 64;

  // Sample k lives in bits [16k+13:16k]; the two top bits of each lane are ignored.
  function automatic logic [SMP_W-1:0] lane_sample(input logic [BEAT_W-1:0] word,
                                                   input logic [1:0]        lane);
    return word[LANE_W*lane +: SMP_W];
  endfunction

endpackage

// File: rtl/axi_dac_reader_fifo.sv
// Single-clock beat FIFO with flush and free-entry count; push and pop may coincide.
module sync_fifo_64
  import axi_dac_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [BEAT_W-1:0] din_i,
  input  logic              pop_i,
  output logic [BEAT_W-1:0] dout_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  free_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [BEAT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  // A pop frees the slot a simultaneous push into a full FIFO needs.
  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign free_o  = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/axi_dac_reader.sv
// AXI3 HP read master streaming a circular DDR sample buffer out as 14-bit DAC samples.
// One-shot playback (ctrl_oneshot_i) is compiled in with AXI_DAC_READER_ONESHOT_EN.
module axi_dac_reader
  import axi_dac_reader_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned AW         = 32
) (
  input  logic          axi_clk_i,
  input  logic          axi_rst_i,
  input  logic          ctrl_start_i,
  input  logic          ctrl_stop_i,
`ifdef AXI_DAC_READER_ONESHOT_EN
  input  logic          ctrl_oneshot_i,
`endif
  input  logic [AW-1:0] cfg_start_addr_i,
  input  logic [AW-1:0] cfg_end_addr_i,
  output logic [AW-1:0] axi_araddr_o,
  output logic [3:0]    axi_arlen_o,
  output logic [2:0]    axi_arsize_o,
  output logic [1:0]    axi_arburst_o,
  output logic          axi_arvalid_o,
  input  logic          axi_arready_i,
  input  logic [63:0]   axi_rdata_i,
  input  logic [1:0]    axi_rresp_i,
  input  logic          axi_rlast_i,
  input  logic          axi_rvalid_i,
  output logic          axi_rready_o,
  output logic [13:0]   smp_o,
  output logic          smp_valid_o,
  input  logic          smp_ready_i,
  output logic          busy_o,
  output logic          err_o,
  output logic          underrun_o
);
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BEAT_CNT_W  = 4;
  localparam int unsigned BURST_BYTES = BURST_LEN * 8;

  state_t            state_q, state_d;
  logic [AW-1:0]     start_q, start_d, end_q, end_d, ptr_q, ptr_d, araddr_q, araddr_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d, busy_q, busy_d;
  logic              err_q, err_d, underrun_q, underrun_d, emitted_q, emitted_d;
  logic              done_q, done_d, oneshot_en;
  logic [BEAT_W-1:0] word_q, word_d;
  logic [1:0]        lane_q, lane_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic              smp_valid_q, smp_valid_d;

  logic              fifo_push, fifo_pop, fifo_empty, flush;
  logic [BEAT_W-1:0] fifo_din, fifo_dout;
  logic [CNT_W-1:0]  fifo_free;
  logic              beat_hs, last_beat, unpack_idle, smp_accept;
  logic [AW-1:0]     ptr_inc;

`ifdef AXI_DAC_READER_ONESHOT_EN
  logic oneshot_q, oneshot_d;
  assign oneshot_en = oneshot_q;
`else
  assign oneshot_en = 1'b0;
`endif

  sync_fifo_64 #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk_i   (axi_clk_i),
    .rst_i   (axi_rst_i),
    .flush_i (flush),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

  // Burst sequencing: one outstanding AR, FIFO space reserved before the request.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    ptr_d      = ptr_q;
    beat_d     = beat_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    err_d      = err_q;
    underrun_d = underrun_q;
    emitted_d  = emitted_q || smp_valid_q;
    done_d     = done_q;
`ifdef AXI_DAC_READER_ONESHOT_EN
    oneshot_d  = oneshot_q;
`endif
    fifo_push   = 1'b0;
    fifo_din    = '0;
    flush       = 1'b0;
    beat_hs     = axi_rvalid_i && rready_q;
    last_beat   = (beat_q == BEAT_CNT_W'(BURST_LEN - 1));
    ptr_inc     = ptr_q + AW'(BURST_BYTES);
    unpack_idle = fifo_empty && (!smp_valid_q || (smp_ready_i && lane_q == 2'(LANES - 1)));

    if ((state_q == ADDR || state_q == DATA) && emitted_q && smp_ready_i && !smp_valid_q)
      underrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (ctrl_start_i && !ctrl_stop_i) begin
          state_d    = ADDR;
          start_d    = cfg_start_addr_i;
          end_d      = cfg_end_addr_i;
          ptr_d      = cfg_start_addr_i;
          err_d      = 1'b0;
          underrun_d = 1'b0;
          emitted_d  = 1'b0;
          done_d     = 1'b0;
`ifdef AXI_DAC_READER_ONESHOT_EN
          oneshot_d  = ctrl_oneshot_i;
`endif
        end
      end
      ADDR: begin
        if (ctrl_stop_i && !(arvalid_q && axi_arready_i)) begin
          state_d   = IDLE;
          arvalid_d = 1'b0;
          flush     = 1'b1;
        end else if (arvalid_q) begin
          if (axi_arready_i) begin
            arvalid_d = 1'b0;
            beat_d    = '0;
            state_d   = ctrl_stop_i ? DRAIN : DATA;
          end
        end else if (done_q) begin
          if (unpack_idle) state_d = IDLE;
        end else if (fifo_free >= CNT_W'(BURST_LEN)) begin
          arvalid_d = 1'b1;
          araddr_d  = ptr_q;
        end
      end
      DATA: begin
        if (beat_hs) begin
          fifo_push = 1'b1;
          fifo_din  = (axi_rresp_i != 2'b00) ? '0 : axi_rdata_i;
          if (axi_rresp_i != 2'b00 || axi_rlast_i != last_beat) err_d = 1'b1;
          beat_d = beat_q + BEAT_CNT_W'(1);
          if (last_beat) begin
            state_d = ADDR;
            if (ptr_inc >= end_q) begin
              ptr_d  = start_q;
              done_d = oneshot_en;
            end else begin
              ptr_d = ptr_inc;
            end
          end
        end
        if (ctrl_stop_i) begin
          if (beat_hs && last_beat) begin
            state_d = IDLE;
            flush   = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Bursts cannot be aborted: swallow beats until the burst is over.
        if (beat_hs) begin
          beat_d = beat_q + BEAT_CNT_W'(1);
          if (axi_rlast_i || last_beat) begin
            state_d = IDLE;
            flush   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    rready_d = (state_d == DATA) || (state_d == DRAIN);
  end

  // Unpacker: one FIFO word yields four samples, lane 0 first, refilled back-to-back.
  always_comb begin
    smp_d       = smp_q;
    smp_valid_d = smp_valid_q;
    word_d      = word_q;
    lane_d      = lane_q;
    smp_accept  = smp_valid_q && smp_ready_i;
    fifo_pop    = !flush && !fifo_empty &&
                  (!smp_valid_q || (smp_accept && lane_q == 2'(LANES - 1)));
    if (flush) begin
      smp_valid_d = 1'b0;
      lane_d      = '0;
    end else if (fifo_pop) begin
      word_d      = fifo_dout;
      lane_d      = '0;
      smp_d       = lane_sample(fifo_dout, 2'd0);
      smp_valid_d = 1'b1;
    end else if (smp_accept) begin
      if (lane_q == 2'(LANES - 1)) begin
        smp_valid_d = 1'b0;
      end else begin
        lane_d = lane_q + 2'd1;
        smp_d  = lane_sample(word_q, lane_q + 2'd1);
      end
    end
  end

  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      state_q     <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      ptr_q       <= '0;
      beat_q      <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      underrun_q  <= 1'b0;
      emitted_q   <= 1'b0;
      done_q      <= 1'b0;
      word_q      <= '0;
      lane_q      <= '0;
      smp_q       <= '0;
      smp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      end_q       <= end_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      underrun_q  <= underrun_d;
      emitted_q   <= emitted_d;
      done_q      <= done_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      smp_q       <= smp_d;
      smp_valid_q <= smp_valid_d;
    end
  end

`ifdef AXI_DAC_READER_ONESHOT_EN
  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) oneshot_q <= 1'b0;
    else           oneshot_q <= oneshot_d;
  end
`endif

  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = 4'(BURST_LEN - 1);
  assign axi_arsize_o  = AXI_SIZE_8B;
  assign axi_arburst_o = AXI_BURST_INCR;
  assign axi_arvalid_o = arvalid_q;
  assign axi_rready_o  = rready_q;
  assign smp_o         = smp_q;
  assign smp_valid_o   = smp_valid_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_axi_dac_reader.sv
// Scoreboard bench for axi_dac_reader: a slave model pushes expected samples, a monitor checks them.
`timescale 1ns/1ps
module tb_axi_dac_reader;
  localparam int BL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_start_i, ctrl_stop_i;
  logic        ctrl_oneshot_i;
  logic [31:0] cfg_start_addr_i, cfg_end_addr_i;
  logic [31:0] axi_araddr_o;
  logic [3:0]  axi_arlen_o;
  logic [2:0]  axi_arsize_o;
  logic [1:0]  axi_arburst_o;
  logic        axi_arvalid_o, axi_arready_i;
  logic [63:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_rlast_i, axi_rvalid_i, axi_rready_o;
  logic [13:0] smp_o;
  logic        smp_valid_o, smp_ready_i, busy_o, err_o, underrun_o;

  int          checks = 0, errors = 0;
  logic [13:0] exp_q[$];
  logic [31:0] ar_log[$];
  int          ar_delay = 0, r_gap = 0, err_beat = -1, cur_beat = -1;
  int          beats_acc = 0, n_smp = 0, gaps = 0, ready_mode = 0;
  bit          slave_busy = 0, sb_en = 1, gap_en = 0, seen = 0;

  always #5 clk = ~clk;

  axi_dac_reader dut (
    .axi_clk_i        (clk),
    .axi_rst_i        (rst),
    .ctrl_start_i     (ctrl_start_i),
    .ctrl_stop_i      (ctrl_stop_i),
`ifdef AXI_DAC_READER_ONESHOT_EN
    .ctrl_oneshot_i   (ctrl_oneshot_i),
`endif
    .cfg_start_addr_i (cfg_start_addr_i),
    .cfg_end_addr_i   (cfg_end_addr_i),
    .axi_araddr_o     (axi_araddr_o),
    .axi_arlen_o      (axi_arlen_o),
    .axi_arsize_o     (axi_arsize_o),
    .axi_arburst_o    (axi_arburst_o),
    .axi_arvalid_o    (axi_arvalid_o),
    .axi_arready_i    (axi_arready_i),
    .axi_rdata_i      (axi_rdata_i),
    .axi_rresp_i      (axi_rresp_i),
    .axi_rlast_i      (axi_rlast_i),
    .axi_rvalid_i     (axi_rvalid_i),
    .axi_rready_o     (axi_rready_o),
    .smp_o            (smp_o),
    .smp_valid_o      (smp_valid_o),
    .smp_ready_i      (smp_ready_i),
    .busy_o           (busy_o),
    .err_o            (err_o),
    .underrun_o       (underrun_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory word i holds sample i+k in lane k; lane top bits carry junk the DUT must ignore.
  function automatic logic [63:0] mem_word(input logic [31:0] addr);
    logic [63:0] w;
    logic [13:0] i;
    i = addr[16:3];
    for (int k = 0; k < 4; k++) w[16*k +: 16] = {2'b10, i + 14'(k)};
    return w;
  endfunction

  // AXI read slave: optional AR delay, gapped R beats, one injected error beat.
  initial begin
    logic [31:0] a;
    bit ok;
    axi_arready_i = 1'b0;
    axi_rvalid_i  = 1'b0;
    axi_rdata_i   = '0;
    axi_rresp_i   = 2'b00;
    axi_rlast_i   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && axi_arvalid_o) begin
        a = axi_araddr_o;
        slave_busy = 1'b1;
        ok = 1'b1;
        for (int d = 0; d < ar_delay; d++) begin
          @(posedge clk); #1;
          if (!axi_arvalid_o) begin ok = 1'b0; break; end
          chk("araddr_stable", 64'(axi_araddr_o), 64'(a));
        end
        if (ok && axi_arvalid_o) begin
          axi_arready_i = 1'b1;
          @(posedge clk); #1;
          axi_arready_i = 1'b0;
          ar_log.push_back(a);
          for (int b = 0; b < BL; b++) begin
            for (int g = 0; g < r_gap; g++) begin @(posedge clk); #1; end
            axi_rvalid_i = 1'b1;
            axi_rlast_i  = (b == BL - 1);
            axi_rdata_i  = mem_word(a + 32'(8 * b));
            cur_beat     = b;
            if (b == err_beat) begin
              axi_rresp_i = 2'b10;
              for (int k = 0; k < 4; k++) exp_q.push_back(14'd0);
            end else begin
              axi_rresp_i = 2'b00;
              for (int k = 0; k < 4; k++) exp_q.push_back(a[16:3] + 14'(b + k));
            end
            chk("rready", 64'(axi_rready_o), 64'd1);
            chk("single_ar", 64'(axi_arvalid_o), 64'd0);
            @(posedge clk); #1;
            axi_rvalid_i = 1'b0;
            axi_rlast_i  = 1'b0;
            axi_rresp_i  = 2'b00;
            beats_acc++;
          end
          err_beat = -1;
        end
        cur_beat   = -1;
        slave_busy = 1'b0;
      end
    end
  end

  // Sample sink ready: 0 = low, 1 = always high, 2 = random 30% high.
  initial begin
    smp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       smp_ready_i = 1'b0;
        1:       smp_ready_i = 1'b1;
        default: smp_ready_i = ($urandom_range(0, 9) < 3);
      endcase
    end
  end

  // Monitor: compares every accepted sample against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (smp_valid_o && smp_ready_i) begin
          if (sb_en) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sample_unexpected: got 0x%0h expected none", smp_o);
            end else begin
              chk("sample", 64'(smp_o), 64'(exp_q.pop_front()));
            end
            n_smp++;
            seen = 1'b1;
          end
        end else if (gap_en && seen && !smp_valid_o) begin
          gaps++;
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 ctrl_start_i = 1'b1;
    @(posedge clk); #1 ctrl_start_i = 1'b0;
  endtask

  task automatic wait_smp(input int n, input int max_cyc);
    int base = n_smp;
    int c = 0;
    while (n_smp - base < n && c < max_cyc) begin @(posedge clk); c++; end
    chk("smp_timeout", 64'(n_smp - base >= n), 64'd1);
  endtask

  task automatic stop_run();
    int c = 0;
    @(posedge clk); #1;
    sb_en = 1'b0;
    ctrl_stop_i = 1'b1;
    @(posedge clk); #1 ctrl_stop_i = 1'b0;
    while ((busy_o || slave_busy) && c < 500) begin @(posedge clk); #1; c++; end
    chk("stop_idle", 64'(busy_o), 64'd0);
    chk("stop_smp_valid", 64'(smp_valid_o), 64'd0);
    exp_q.delete();
    sb_en = 1'b1;
  endtask

  initial begin
    int c, ar0, b0;
    rst = 1'b1;
    ctrl_start_i = 1'b0;
    ctrl_stop_i = 1'b0;
    ctrl_oneshot_i = 1'b0;
    cfg_start_addr_i = 32'h1000;
    cfg_end_addr_i = 32'h1100;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_arvalid", 64'(axi_arvalid_o), 64'd0);
    chk("rst_rready", 64'(axi_rready_o), 64'd0);
    chk("rst_smp_valid", 64'(smp_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_underrun", 64'(underrun_o), 64'd0);
    chk("rst_araddr", 64'(axi_araddr_o), 64'd0);
    chk("arlen", 64'(axi_arlen_o), 64'd15);
    chk("arsize", 64'(axi_arsize_o), 64'd3);
    chk("arburst", 64'(axi_arburst_o), 64'd1);

    // Circular playback 0x1000..0x1100 with a always-ready sink.
    ar_log.delete();
    ready_mode = 1;
    gap_en = 1'b1;
    seen = 1'b0;
    do_start();
    wait_smp(300, 3000);
    chk("ar_count_ge3", 64'(ar_log.size() >= 3), 64'd1);
    if (ar_log.size() >= 3) begin
      chk("ar0", 64'(ar_log[0]), 64'h1000);
      chk("ar1", 64'(ar_log[1]), 64'h1080);
      chk("ar2_wrap", 64'(ar_log[2]), 64'h1000);
    end
    chk("no_gaps", 64'(gaps), 64'd0);
    chk("t1_underrun", 64'(underrun_o), 64'd0);
    chk("t1_err", 64'(err_o), 64'd0);
    chk("t1_busy", 64'(busy_o), 64'd1);
    gap_en = 1'b0;
    stop_run();

    // Backpressure: sink ready 30% of cycles.
    ready_mode = 2;
    do_start();
    wait_smp(300, 6000);
    chk("bp_err", 64'(err_o), 64'd0);
    stop_run();

    // Stop on beat 5 of 16: the rest of the burst is drained, then idle.
    ready_mode = 1;
    ar0 = ar_log.size();
    b0 = beats_acc;
    do_start();
    c = 0;
    while (cur_beat != 4 && c < 500) begin @(posedge clk); #2; c++; end
    chk("stop_beat_reached", 64'(cur_beat == 4), 64'd1);
    sb_en = 1'b0;
    ctrl_stop_i = 1'b1;
    @(posedge clk); #1 ctrl_stop_i = 1'b0;
    c = 0;
    while (busy_o && c < 200) begin @(posedge clk); #1; c++; end
    chk("drain_idle", 64'(busy_o), 64'd0);
    chk("drain_beats", 64'(beats_acc - b0), 64'd16);
    chk("drain_smp_valid", 64'(smp_valid_o), 64'd0);
    repeat (50) @(posedge clk);
    #1;
    chk("drain_no_more_ar", 64'(ar_log.size() - ar0), 64'd1);
    chk("drain_rready", 64'(axi_rready_o), 64'd0);
    exp_q.delete();
    sb_en = 1'b1;

    // Error response on beat 3: samples zeroed, err sticky until the next start.
    err_beat = 2;
    do_start();
    wait_smp(200, 3000);
    chk("err_set", 64'(err_o), 64'd1);
    chk("err_busy", 64'(busy_o), 64'd1);
    stop_run();
    chk("err_sticky_idle", 64'(err_o), 64'd1);
    do_start();
    chk("err_cleared", 64'(err_o), 64'd0);
    stop_run();

    // Slow slave: delayed AR, sparse R beats starve the sink.
    ar_delay = 7;
    r_gap = 5;
    do_start();
    wait_smp(100, 5000);
    chk("underrun_set", 64'(underrun_o), 64'd1);
    stop_run();
    ar_delay = 0;
    r_gap = 0;

`ifdef AXI_DAC_READER_ONESHOT_EN
    // One-shot: 0x0..0x100 is exactly 128 samples, then idle.
    cfg_start_addr_i = 32'h0;
    cfg_end_addr_i = 32'h100;
    ctrl_oneshot_i = 1'b1;
    ar0 = ar_log.size();
    b0 = n_smp;
    do_start();
    ctrl_oneshot_i = 1'b0;
    c = 0;
    while (busy_o && c < 3000) begin @(posedge clk); #1; c++; end
    chk("os_idle", 64'(busy_o), 64'd0);
    chk("os_samples", 64'(n_smp - b0), 64'd128);
    chk("os_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("os_ar_count", 64'(ar_log.size() - ar0), 64'd2);
    chk("os_smp_valid", 64'(smp_valid_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
